// File: rtl/switch_debouncer.sv
// -----------------------------------------------------------------------------
// switch_debouncer
//
// Synchronises and debounces the board slide switches. It presents a clean,
// zero-extended 24-bit display word for the seven-segment DisplayController.
// It also emits a one-cycle strobe whenever the debounced value changes, so
// downstream logic can latch switch events without polling.
//
// Parameters:
//   WIDTH          number of switch inputs debounced (1..24)
//   STABLE_CYCLES  consecutive cycles a synchronised input must differ from
//                  its accepted value before it is accepted (>= 2)
//
// Ports:
//   clk           system clock
//   rst           synchronous, active-high reset
//   sw_raw        asynchronous switch inputs
//   sw_stable     debounced switch value
//   sw_changed    one-cycle pulse in the cycle sw_stable takes a new value
//   display_data  display word: zero-extended sw_stable
//
// Optional feature, enabled by defining SWITCH_DEBOUNCE_CHANGE_COUNT_EN:
//   An 8-bit wrapping count of sw_changed pulses is placed in
//   display_data[23:16], and display_data[15:0] carries sw_stable.
//   WIDTH must then be 16 or less.
// -----------------------------------------------------------------------------
module switch_debouncer #(
  parameter int WIDTH         = 5,
  parameter int STABLE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic             sw_changed,
  output logic [23:0]      display_data
);

  // The counter only ever holds 0..STABLE_CYCLES-1, so clog2 bits suffice.
  localparam int            CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] TC = CW'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable_nxt;
  logic [CW-1:0]    cnt     [WIDTH];
  logic [CW-1:0]    cnt_nxt [WIDTH];

  // Per-bit debounce decision. Any sample matching the accepted level
  // restarts the count. The terminal compare fires before the counter can
  // wrap, and it also clears the counter for the next change.
  always_comb begin
    stable_nxt = sw_stable;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = '0;
      if (sync2[i] != sw_stable[i]) begin
        if (cnt[i] == TC) begin
          stable_nxt[i] = sync2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= '0;
      sync2      <= '0;
      sw_stable  <= '0;
      sw_changed <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1      <= sw_raw;
      sync2      <= sync1;
      sw_stable  <= stable_nxt;
      // The strobe is registered on the same edge as the new value, so it
      // is high exactly in the cycle where sw_stable first shows the change.
      sw_changed <= (stable_nxt != sw_stable);
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

`ifdef SWITCH_DEBOUNCE_CHANGE_COUNT_EN
  logic [7:0] change_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      change_count <= 8'h00;
    end else if (sw_changed) begin
      change_count <= change_count + 8'h01;
    end
  end

  assign display_data = {change_count, 16'(sw_stable)};
`else
  assign display_data = 24'(sw_stable);
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// -----------------------------------------------------------------------------
// tb_switch_debouncer
//
// Self-checking bench for switch_debouncer with WIDTH = 5, STABLE_CYCLES = 4.
// The reference model accepts a bit when the last STABLE_CYCLES synchronised
// samples all differ from the accepted level. The model is built from a
// shift history of samples, not from a counter.
// -----------------------------------------------------------------------------
module tb_switch_debouncer;

  localparam int W = 5;
  localparam int S = 4;

  logic          clk;
  logic          rst;
  logic [W-1:0]  sw_raw;
  logic [W-1:0]  sw_stable;
  logic          sw_changed;
  logic [23:0]   display_data;

  int vectors;
  int miscompares;

  switch_debouncer #(.WIDTH(W), .STABLE_CYCLES(S)) dut (
    .clk          (clk),
    .rst          (rst),
    .sw_raw       (sw_raw),
    .sw_stable    (sw_stable),
    .sw_changed   (sw_changed),
    .display_data (display_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [W-1:0] m_s1, m_s2, m_stable;
  logic         m_changed;
  logic [7:0]   m_count;
  logic [W-1:0] m_hist [S];   // index 0 = most recent synchronised sample

  task automatic model_edge(input logic r, input logic [W-1:0] raw);
    logic [W-1:0] nstab;
    logic         flip;
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_changed = 1'b0; m_count = 8'h00;
      for (int k = 0; k < S; k++) m_hist[k] = '0;
    end else begin
      if (m_changed) m_count = m_count + 8'h01;
      for (int k = S - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = m_s2;
      nstab = m_stable;
      for (int b = 0; b < W; b++) begin
        flip = 1'b1;
        for (int k = 0; k < S; k++)
          if (m_hist[k][b] == m_stable[b]) flip = 1'b0;
        if (flip) nstab[b] = ~m_stable[b];
      end
      m_changed = (nstab != m_stable);
      m_stable  = nstab;
      m_s2      = m_s1;
      m_s1      = raw;
    end
  endtask

  function automatic logic [23:0] model_display();
`ifdef SWITCH_DEBOUNCE_CHANGE_COUNT_EN
    return {m_count, 16'(m_stable)};
`else
    return 24'(m_stable);
`endif
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, update the model, sample #1 later
  // and compare the DUT against the model.
  task automatic step(input logic r, input logic [W-1:0] raw);
    rst    = r;
    sw_raw = raw;
    @(posedge clk);
    model_edge(r, raw);
    #1;
    chk("model_stable",  24'(sw_stable),  24'(m_stable));
    chk("model_changed", 24'(sw_changed), 24'(m_changed));
    chk("model_display", display_data,    model_display());
  endtask

  // Fixed expectations; only the switch field of the display is compared here
  // so that the table is valid whether or not the change counter is built.
  task automatic chk_fixed(input string name, input logic [W-1:0] es, input logic ec);
    chk({name, "_stable"},  24'(sw_stable),          24'(es));
    chk({name, "_changed"}, 24'(sw_changed),         24'(ec));
    chk({name, "_disp"},    24'(display_data[15:0]), 24'(es));
  endtask

  typedef struct {
    logic          r;
    logic [W-1:0]  raw;
    logic [W-1:0]  exp_stable;
    logic          exp_changed;
  } vec_t;

  vec_t tbl [$];

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    sw_raw      = '0;
    m_s1 = '0; m_s2 = '0; m_stable = '0; m_changed = 1'b0; m_count = 8'h00;
    for (int k = 0; k < S; k++) m_hist[k] = '0;

    // Reset held 3 cycles with all switches high, then release: the value
    // appears on the 6th edge after release. Then fall to 0 and step to 15.
    for (int i = 0; i < 3; i++) tbl.push_back('{1'b1, 5'h1F, 5'h00, 1'b0});
    for (int i = 0; i < 5; i++) tbl.push_back('{1'b0, 5'h1F, 5'h00, 1'b0});
    tbl.push_back('{1'b0, 5'h1F, 5'h1F, 1'b1});
    tbl.push_back('{1'b0, 5'h1F, 5'h1F, 1'b0});
    for (int i = 0; i < 5; i++) tbl.push_back('{1'b0, 5'h00, 5'h1F, 1'b0});
    tbl.push_back('{1'b0, 5'h00, 5'h00, 1'b1});
    tbl.push_back('{1'b0, 5'h00, 5'h00, 1'b0});
    for (int i = 0; i < 5; i++) tbl.push_back('{1'b0, 5'h15, 5'h00, 1'b0});
    tbl.push_back('{1'b0, 5'h15, 5'h15, 1'b1});
    tbl.push_back('{1'b0, 5'h15, 5'h15, 1'b0});

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].raw);
      chk_fixed("table", tbl[i].exp_stable, tbl[i].exp_changed);
    end
    chk("clean_step_display", display_data[15:0], 24'h000015);

    // Back to zero.
    for (int i = 0; i < 8; i++) step(1'b0, 5'h00);
    chk_fixed("zeroed", 5'h00, 1'b0);

    // 3-cycle glitch on bit 0 is rejected.
    for (int i = 0; i < 11; i++) begin
      step(1'b0, (i < 3) ? 5'h01 : 5'h00);
      chk_fixed("glitch3", 5'h00, 1'b0);
    end

    // A pulse of exactly 4 cycles is accepted, then released again.
    for (int i = 0; i < 12; i++) begin
      step(1'b0, (i < 4) ? 5'h01 : 5'h00);
      chk_fixed("pulse4", (i >= 5 && i < 9) ? 5'h01 : 5'h00, (i == 5 || i == 9));
    end

    // Bounce 1,0,1,1,1,1 then held: accepted on the 8th edge (index 7).
    for (int i = 0; i < 10; i++) begin
      step(1'b0, (i == 1) ? 5'h00 : 5'h01);
      chk_fixed("bounce", (i >= 7) ? 5'h01 : 5'h00, (i == 7));
    end

    for (int i = 0; i < 8; i++) step(1'b0, 5'h00);

    // Staggered: bit 4 rises, bit 1 rises 2 cycles later.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, (i >= 2) ? 5'h12 : 5'h10);
      chk_fixed("stagger", (i >= 7) ? 5'h12 : ((i >= 5) ? 5'h10 : 5'h00),
                (i == 5 || i == 7));
    end

    // Reset mid-count: bit 2 counted twice, reset, then full latency again.
    step(1'b1, 5'h00);
    chk_fixed("midrst_pre", 5'h00, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step((i == 4), 5'h04);
      chk_fixed("midrst", (i >= 10) ? 5'h04 : 5'h00, (i == 10));
    end

`ifdef SWITCH_DEBOUNCE_CHANGE_COUNT_EN
    // 257 accepted toggles of bit 0 from reset: count wraps to 1, bit 0 high.
    step(1'b1, 5'h00);
    for (int t = 0; t < 257; t++) begin
      for (int i = 0; i < 6; i++) step(1'b0, (t % 2 == 0) ? 5'h01 : 5'h00);
    end
    step(1'b0, 5'h01);
    chk("count_wrap", display_data, 24'h010001);
`endif

    // Randomised bouncing switches with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      logic [W-1:0] raw;
      raw = sw_raw;
      if ($urandom_range(0, 5) == 0) raw[$urandom_range(0, W-1)] ^= 1'b1;
      step(($urandom_range(0, 399) == 0), raw);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/switch_debouncer.md
# switch_debouncer

Synchronises and debounces the board slide switches and presents a clean, zero-extended 24-bit value for the seven-segment `DisplayController` input (`data_to_display`). It sits directly upstream of the display path in the I/O test tops, replacing the raw, unsynchronised switch wiring. It also emits a one-cycle change strobe, so later MMIO logic can latch switch events without polling.

## Interface
- `WIDTH`, default 5: number of switch inputs debounced (1..24).
- `STABLE_CYCLES`, default 500000: consecutive cycles a synchronised input must differ from its accepted value before it is accepted (10 ms at 50 MHz). Legal range is 2 or more.
- `clk`  in  1: system clock.
- `rst`  in  1: synchronous, active-high reset.
- `sw_raw`  in  WIDTH: asynchronous switch inputs.
- `sw_stable`  out  WIDTH: debounced switch value.
- `sw_changed`  out  1: one-cycle pulse when any bit of `sw_stable` changes.
- `display_data`  out  24: display word for `DisplayController`.

## Operation
- Synchroniser: two flip-flop stages per bit (`sync1`, `sync2`), both reset to 0.
- Per-bit counter `cnt[i]`:
  - Width is `$clog2(STABLE_CYCLES)`.
  - Resets to 0.
  - Each bit has its own counter, and bits are fully independent.
- Per-bit rule, evaluated each rising edge:
  - If `sync2[i] == sw_stable[i]`: `cnt[i]` is set to 0. Any bounce back to the accepted level restarts the count.
  - Else, if `cnt[i] == STABLE_CYCLES-1`: `sw_stable[i]` is set to `sync2[i]` and `cnt[i]` is set to 0.
  - Else: `cnt[i]` is incremented by 1. It never wraps, because the terminal compare fires first.
- `sw_changed` is registered. It is 1 in exactly the cycles in which `sw_stable` holds a value different from its previous cycle.
  - Several bits accepted on the same edge produce a single pulse.
  - Bits accepted on different edges produce separate pulses, including back-to-back pulses.
- `display_data` is `{(24-WIDTH)'b0, sw_stable}` when the change counter is compiled out; see Configuration for the alternative.
- Reset values: `sw_stable` = 0, `sw_changed` = 0, `display_data` = 0, all counters = 0.
- Reset mid-count: all counts are discarded. A switch still held high after reset goes through the full latency again from the reset release.

## Timing
- Latency: `sw_raw` changes before rising edge E0 and holds. `sw_stable` and `sw_changed` show the new value after edge E(STABLE_CYCLES+1), which is `STABLE_CYCLES`+2 edges counted from E0.
  - 2 edges are for synchronisation.
  - `STABLE_CYCLES` edges are for counting.
- Glitch rejection: a pulse on `sw_raw` lasting fewer than `STABLE_CYCLES` cycles (as seen at `sync2`) never reaches `sw_stable`.
- A pulse of exactly `STABLE_CYCLES` cycles is accepted.
- `display_data` is driven combinationally from registers; there is no extra latency relative to `sw_stable`.
- `sw_changed` is high for exactly 1 cycle per accepted change.

## Configuration
- Macro `SWITCH_DEBOUNCE_CHANGE_COUNT_EN`.
- Defined:
  - An 8-bit register `change_count` resets to 0.
  - It increments by 1 on every cycle where `sw_changed` is 1, wrapping 8'hFF to 8'h00.
  - `display_data[23:16]` = `change_count`.
  - `display_data[15:0]` = zero-extended `sw_stable`.
  - In this mode `WIDTH` must be 16 or less.
- Undefined: no counter is built, and `display_data` is the plain zero-extended `sw_stable`.

## Test plan
All scenarios use `STABLE_CYCLES` = 4 and `WIDTH` = 5.
- Reset: assert `rst` for 3 cycles with `sw_raw` = 5'h1F -> `sw_stable`, `sw_changed` and `display_data` are 0 during reset. After release, `sw_stable` = 5'h1F on the 6th edge and `display_data` = 24'h00001F.
- Clean step: `sw_raw` goes 5'h00 to 5'h15 before edge E0 and holds -> `sw_stable` = 5'h15 and `sw_changed` = 1 after E5 only, and `display_data` = 24'h000015.
- Glitch: bit 0 goes high for 3 cycles then low -> `sw_stable` stays 0 and no pulse. Bounce sequence 1,0,1,1,1,1 on bit 0 -> accepted 4 edges after the last rising transition reaches `sync2`.
- Staggered bits: bit 4 rises, then bit 1 rises 2 cycles later -> two separate single-cycle `sw_changed` pulses 2 cycles apart, ending with `sw_stable` = 5'h12.
- Reset mid-count: bit 2 high for 2 counted cycles, `rst` for 1 cycle, bit 2 held high -> `sw_stable[2]` rises only at the full latency after the reset release.
- With `SWITCH_DEBOUNCE_CHANGE_COUNT_EN`: 257 accepted toggles of bit 0 -> `display_data[23:16]` = 8'h01 and `display_data[15:0]` = 16'h0001.
